// File: rtl/axi_lite_selftest_master.sv
// AXI4-Lite master: writes a seeded pattern over a strided register window, reads it back, compares.
// Optional build macro SELFTEST_STOP_ON_ERR_EN ends the test at the first error of any kind.
// state   | meaning
// IDLE    | waiting for start
// WR      | AW and W channels in flight
// WR_RESP | waiting for write response
// RD      | AR channel in flight
// RD_DATA | waiting for read data
// CHECK   | compare read-back against pattern
// FIN     | one-cycle done, result latched
module axi_lite_selftest_master #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_VECTORS    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    ADDR_STRIDE    = 4,
  parameter logic [63:0]           PATTERN_INC    = 64'h0000_0000_9E37_79B9,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   seed,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [8:0]              err_count,
  output logic                    timeout,
  output logic [7:0]              first_err_idx,
  output logic [DATA_WIDTH-1:0]   first_err_data,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);
  localparam int                    TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]         TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] PAT_STEP  = PATTERN_INC[DATA_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(ADDR_STRIDE);
  localparam logic [7:0]            LAST_IDX  = 8'(NUM_VECTORS - 1);
`ifdef SELFTEST_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD, S_RD_DATA, S_CHECK, S_FIN} state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           tmo_cnt;
  logic                    tmo_hit, tmo_ev, err_ev;
  logic                    aw_done_q, w_done_q;
  logic [DATA_WIDTH-1:0]   vec_q, rdata_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              idx_q;
  logic                    rbad_q;

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN);
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = vec_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = '1;
  assign tmo_hit      = (tmo_cnt == '0);

  always_comb begin
    state_d       = state_q;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    tmo_ev        = 1'b0;
    err_ev        = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_WR;
      S_WR: begin
        m_axi_awvalid = !aw_done_q;
        m_axi_wvalid  = !w_done_q;
        if ((aw_done_q || m_axi_awready) && (w_done_q || m_axi_wready)) state_d = S_WR_RESP;
        else if (tmo_hit) begin state_d = S_FIN; tmo_ev = 1'b1; end
      end
      S_WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          err_ev  = (m_axi_bresp != 2'b00);
          state_d = (STOP_ON_ERR && err_ev) ? S_FIN : S_RD;
        end else if (tmo_hit) begin state_d = S_FIN; tmo_ev = 1'b1; end
      end
      S_RD: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = S_RD_DATA;
        else if (tmo_hit) begin state_d = S_FIN; tmo_ev = 1'b1; end
      end
      S_RD_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_d = S_CHECK;
        else if (tmo_hit) begin state_d = S_FIN; tmo_ev = 1'b1; end
      end
      S_CHECK: begin
        // a bad rresp is the error for this vector; the data is not compared then
        err_ev  = rbad_q || (rdata_q != vec_q);
        state_d = ((idx_q == LAST_IDX) || (STOP_ON_ERR && err_ev)) ? S_FIN : S_WR;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q        <= S_IDLE;
      tmo_cnt        <= TMO_LOAD;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      vec_q          <= '0;
      addr_q         <= '0;
      idx_q          <= '0;
      rdata_q        <= '0;
      rbad_q         <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      timeout        <= 1'b0;
      first_err_idx  <= '0;
      first_err_data <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) tmo_cnt <= TMO_LOAD;
      else if (!tmo_hit)      tmo_cnt <= tmo_cnt - TW'(1);
      if (state_q != S_WR) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (m_axi_awvalid && m_axi_awready) aw_done_q <= 1'b1;
        if (m_axi_wvalid && m_axi_wready)   w_done_q  <= 1'b1;
      end
      if (state_q == S_IDLE && start) begin
        vec_q          <= seed;
        addr_q         <= BASE_ADDR;
        idx_q          <= '0;
        pass           <= 1'b0;
        err_count      <= '0;
        timeout        <= 1'b0;
        first_err_idx  <= '0;
        first_err_data <= '0;
      end
      if (state_q == S_RD_DATA && m_axi_rvalid) begin
        rdata_q <= m_axi_rdata;
        rbad_q  <= (m_axi_rresp != 2'b00);
      end
      if (err_ev) begin
        if (err_count != 9'd511) err_count <= err_count + 9'd1;
        if (err_count == 9'd0) begin
          first_err_idx <= idx_q;
          if (state_q == S_CHECK) first_err_data <= rdata_q;
        end
      end
      if (tmo_ev) timeout <= 1'b1;
      if (state_q == S_CHECK && state_d == S_WR) begin
        idx_q  <= idx_q + 8'd1;
        vec_q  <= vec_q + PAT_STEP;
        addr_q <= addr_q + ADDR_STEP;
      end
      // result is valid in the same cycle as done
      if (state_d == S_FIN && state_q != S_FIN)
        pass <= (err_count == 9'd0) && !err_ev && !timeout && !tmo_ev;
    end
  end
endmodule
